// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: shared definitions for the DRAM port arbiter.
//   state_e                        : arbiter FSM states.
//   REQ_FETCH/REQ_LOAD/REQ_STORE   : requester indices on the req vectors.
package dram_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam int REQ_FETCH = 0;
    localparam int REQ_LOAD  = 1;
    localparam int REQ_STORE = 2;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req [N]  : request vector.
//   ptr      : index that has highest priority this round.
//   gnt [N]  : one-hot winner (all zero when nothing requests).
//   idx      : winner index (0 when nothing requests).
// The pointer register lives in the caller.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] pos;

    always_comb begin
        gnt = '0;
        idx = '0;
        pos = '0;
        // Walk from the farthest offset back to ptr; the nearest requester
        // is the last one written and therefore wins.
        for (int i = N - 1; i >= 0; i--) begin
            pos = IW'((int'(ptr) + i) % N);
            if (req[pos]) begin
                gnt      = '0;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter: shares one byte-wide DRAM port between fetch (0), load (1)
// and store (2). Whole bursts are arbitrated; one beat per cycle is issued.
//   clk, rst           : clock, asynchronous active-high reset.
//   req/req_we/req_addr/req_len/req_wdata : per-requester burst request.
//   gnt, wr_ready, xfer_done               : per-requester handshake.
//   rd_valid, rd_data  : read beat return to the owner.
//   busy               : arbiter not idle.
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : DRAM port.
// Build option: DRAM_ARB_FETCH_PRIO_EN gives fetch absolute priority; the
// remaining requesters rotate among themselves.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 20
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req,
    input  logic [NUM_REQ-1:0]                   req_we,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][LEN_WIDTH-1:0]    req_len,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]                   gnt,
    output logic [NUM_REQ-1:0]                   wr_ready,
    output logic                                 rd_valid,
    output logic [DATA_WIDTH-1:0]                rd_data,
    output logic [NUM_REQ-1:0]                   xfer_done,
    output logic                                 busy,
    output logic                                 mem_en,
    output logic                                 mem_we,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    output logic [DATA_WIDTH-1:0]                mem_wdata,
    input  logic [DATA_WIDTH-1:0]                mem_rdata
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e                 state;
    logic [IW-1:0]          rr_ptr, owner, next_ptr;
    logic                   cur_we, rd_vld;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [LEN_WIDTH-1:0]   cnt;
    logic [NUM_REQ-1:0]     arb_req, rr_gnt, win_gnt;
    logic [IW-1:0]          rr_idx, win_idx;

    always_comb begin
        arb_req = req;
`ifdef DRAM_ARB_FETCH_PRIO_EN
        arb_req[REQ_FETCH] = 1'b0;
`endif
    end

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
        .req (arb_req),
        .ptr (rr_ptr),
        .gnt (rr_gnt),
        .idx (rr_idx)
    );

    always_comb begin
        win_gnt = rr_gnt;
        win_idx = rr_idx;
`ifdef DRAM_ARB_FETCH_PRIO_EN
        if (req[REQ_FETCH]) begin
            win_gnt            = '0;
            win_gnt[REQ_FETCH] = 1'b1;
            win_idx            = IW'(REQ_FETCH);
        end
`endif
    end

    always_comb begin
        next_ptr = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);
`ifdef DRAM_ARB_FETCH_PRIO_EN
        // Fetch never takes part in the rotation.
        if (next_ptr == IW'(REQ_FETCH)) next_ptr = IW'(REQ_FETCH + 1);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            gnt    <= '0;
            owner  <= '0;
            rr_ptr <= '0;
            cur_we <= 1'b0;
            addr   <= '0;
            cnt    <= '0;
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= mem_en & ~mem_we;
            case (state)
                S_IDLE: if (|req) begin
                    gnt    <= win_gnt;
                    owner  <= win_idx;
                    cur_we <= req_we[win_idx];
                    addr   <= req_addr[win_idx];
                    cnt    <= req_len[win_idx];
                    // A zero-length burst idles one cycle in S_DRAIN so its
                    // completion lands two cycles after the request.
                    state  <= (req_len[win_idx] == '0) ? S_DRAIN : S_ISSUE;
                end
                S_ISSUE: begin
                    addr <= addr + ADDR_WIDTH'(1);
                    cnt  <= cnt - LEN_WIDTH'(1);
                    if (cnt == LEN_WIDTH'(1)) state <= cur_we ? S_DONE : S_DRAIN;
                end
                S_DRAIN: state <= S_DONE;
                S_DONE: begin
                    rr_ptr <= next_ptr;
                    gnt    <= '0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_en    = (state == S_ISSUE);
        mem_we    = mem_en & cur_we;
        mem_addr  = mem_en ? addr : '0;
        mem_wdata = mem_we ? req_wdata[owner] : '0;
        wr_ready  = mem_we ? gnt : '0;
        xfer_done = (state == S_DONE) ? gnt : '0;
        busy      = (state != S_IDLE);
        rd_valid  = rd_vld;
        rd_data   = rd_vld ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_dram_arbiter.sv
module tb_dram_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]        req, req_we, gnt, wr_ready, xfer_done;
  logic [2:0][23:0]  req_addr;
  logic [2:0][19:0]  req_len;
  logic [2:0][7:0]   req_wdata;
  logic              rd_valid, busy, mem_en, mem_we;
  logic [7:0]        rd_data, mem_wdata, mem_rdata;
  logic [23:0]       mem_addr;

  dram_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_len(req_len), .req_wdata(req_wdata), .gnt(gnt), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .xfer_done(xfer_done), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // DRAM stand-in: 4 KB aliased over the 24-bit space, 1-cycle read latency.
  function automatic logic [7:0] pat(input logic [11:0] a);
    return 8'(int'(a) * 7 + 3);
  endfunction

  logic [7:0] dram [4096];
  bit         dv   [4096];
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      dram[mem_addr[11:0]] <= mem_wdata;
      dv[mem_addr[11:0]]   <= 1'b1;
    end
    if (mem_en && !mem_we)
      mem_rdata <= dv[mem_addr[11:0]] ? dram[mem_addr[11:0]] : pat(mem_addr[11:0]);
  end

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic expect_out(input string t, input logic [2:0] e_gnt, input logic [2:0] e_wr,
                            input logic [2:0] e_done, input logic e_en, input logic e_we,
                            input logic [23:0] e_addr, input logic [7:0] e_wd, input logic e_rv,
                            input logic [7:0] e_rd, input logic e_busy);
    chk({t, " gnt"}, 32'(gnt), 32'(e_gnt));
    chk({t, " wr_ready"}, 32'(wr_ready), 32'(e_wr));
    chk({t, " xfer_done"}, 32'(xfer_done), 32'(e_done));
    chk({t, " mem_en"}, 32'(mem_en), 32'(e_en));
    chk({t, " mem_we"}, 32'(mem_we), 32'(e_we));
    chk({t, " mem_addr"}, 32'(mem_addr), 32'(e_addr));
    chk({t, " mem_wdata"}, 32'(mem_wdata), 32'(e_wd));
    chk({t, " rd_valid"}, 32'(rd_valid), 32'(e_rv));
    chk({t, " rd_data"}, 32'(rd_data), 32'(e_rd));
    chk({t, " busy"}, 32'(busy), 32'(e_busy));
  endtask

  // ---------------- reference model (burst level) ----------------
  logic [7:0]  ref_mem [4096];
  int          ref_ptr;
  logic        g_we    [3];
  logic [23:0] g_addr  [3];
  int          g_len   [3];
  int          g_rereq [3];
  logic [7:0]  g_w     [3][64];
  int          obs_order[$], obs_done[$], obs_beats;

  function automatic int pick(input logic [2:0] p, input int ptr);
`ifdef DRAM_ARB_FETCH_PRIO_EN
    if (p[0]) return 0;
`endif
    for (int k = 0; k < 3; k++)
      if (p[(ptr + k) % 3]) return (ptr + k) % 3;
    return 0;
  endfunction

  function automatic int after(input int o);
    int n = (o + 1) % 3;
`ifdef DRAM_ARB_FETCH_PRIO_EN
    if (n == 0) n = 1;
`endif
    return n;
  endfunction

  // Requester i issues the burst in g_*[i] for every set bit of mask; fetch
  // re-requests g_rereq[0] extra times. Called just after a rising edge;
  // returns just after a rising edge, one idle cycle past the last burst.
  task automatic run_group(input logic [2:0] mask);
    logic [2:0] pend, drop;
    int c, o, start, L, drel, t_free, rel, wptr[3], rq[3];
    bit active, done_now;
    logic [2:0] e_gnt, e_wr, e_done;
    logic e_en, e_we, e_rv;
    logic [23:0] e_addr, a;
    logic [7:0] e_wd, e_rd;
    string t;
    obs_order.delete(); obs_done.delete(); obs_beats = 0;
    pend = mask; t_free = 0; active = 0; c = 0; o = 0; start = 0; L = 0; drel = 0;
    for (int i = 0; i < 3; i++) begin
      req[i] = mask[i]; req_we[i] = g_we[i]; req_addr[i] = g_addr[i];
      req_len[i] = 20'(g_len[i]); wptr[i] = 0; rq[i] = g_rereq[i];
      req_wdata[i] = g_w[i][0];
    end
    while ((pend != 0 || active) && c < 2000) begin
      if (!active && c == t_free) begin
        o = pick(pend, ref_ptr); start = c; L = g_len[o]; active = 1;
        drel = (L == 0) ? 2 : (g_we[o] ? L + 1 : L + 2);
      end
      @(negedge clk);
      e_gnt = 0; e_wr = 0; e_done = 0; e_en = 0; e_we = 0; e_addr = 0;
      e_wd = 0; e_rv = 0; e_rd = 0;
      rel = c - start;
      if (active && rel >= 1) begin
        e_gnt = 3'(1 << o);
        if (rel <= L) begin
          e_en = 1; e_addr = g_addr[o] + 24'(rel - 1);
          if (g_we[o]) begin e_we = 1; e_wd = g_w[o][rel - 1]; e_wr = e_gnt; end
        end
        if (!g_we[o] && rel >= 2 && rel <= L + 1) begin
          a = g_addr[o] + 24'(rel - 2); e_rv = 1; e_rd = ref_mem[a[11:0]];
        end
        if (rel == drel) e_done = e_gnt;
      end
      t = $sformatf("c%0d o%0d", c, o);
      expect_out(t, e_gnt, e_wr, e_done, e_en, e_we, e_addr, e_wd, e_rv, e_rd,
                 active && rel >= 1);
      done_now = active && rel == drel;
      // requester side reacts to what the DUT shows
      drop = 0;
      if (mem_en) obs_beats++;
      for (int i = 0; i < 3; i++) begin
        if (wr_ready[i] && wptr[i] < 63) wptr[i]++;
        if (xfer_done[i]) begin
          obs_order.push_back(i); obs_done.push_back(c);
          if (rq[i] > 0) begin rq[i]--; wptr[i] = 0; end
          else drop[i] = 1;
        end
      end
      @(posedge clk); #1;
      if (done_now) begin
        if (g_we[o])
          for (int k = 0; k < L; k++) begin
            a = g_addr[o] + 24'(k); ref_mem[a[11:0]] = g_w[o][k];
            chk($sformatf("dram byte %0h", a), 32'(dv[a[11:0]] ? dram[a[11:0]] : pat(a[11:0])),
                32'(ref_mem[a[11:0]]));
          end
        ref_ptr = after(o); active = 0; t_free = c + 1;
      end
      for (int i = 0; i < 3; i++) begin
        if (drop[i]) begin req[i] = 0; pend[i] = 0; end
        req_wdata[i] = g_w[i][wptr[i]];
      end
      c++;
    end
    if (c >= 2000) begin
      total++; bad++;
      $display("FAIL run_group budget: got %0d cycles want <2000", c);
      req = 0;
    end
    @(negedge clk);
    expect_out("post-idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; req = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0; ref_ptr = 0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [23:0] ad, input int len,
                         input logic [7:0] base);
    g_we[i] = we; g_addr[i] = ad; g_len[i] = len; g_rereq[i] = 0;
    for (int k = 0; k < 64; k++) g_w[i][k] = base + 8'(k);
  endtask

  typedef struct {
    int idx; logic we; logic [23:0] addr; int len; int exp_done; int exp_beats;
  } vec_t;

  vec_t vt[7];
  int   seen;
  int   exp_ord[$], exp_dn[$];
  logic [2:0] m;

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = pat(12'(i));
    for (int i = 0; i < 3; i++) set_req(i, 0, 0, 0, 0);
    rst = 1; req = 0; req_we = 0; req_addr = 0; req_len = 0; req_wdata = 0;
    #2;
    expect_out("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1 rst = 0; ref_ptr = 0;

    // idx, we, addr, len, done cycle, beats
    vt[0] = '{0, 1'b0, 24'h000010, 8, 10, 8};   // single read
    vt[1] = '{2, 1'b1, 24'h000100, 4, 5, 4};    // single write A0..A3
    vt[2] = '{2, 1'b0, 24'h000100, 4, 6, 4};    // read back the write
    vt[3] = '{0, 1'b0, 24'hFFFFFE, 4, 6, 4};    // address wrap
    vt[4] = '{1, 1'b0, 24'h000300, 0, 2, 0};    // zero length
    vt[5] = '{1, 1'b1, 24'h000200, 1, 2, 1};    // single-beat write
    vt[6] = '{0, 1'b1, 24'hFFFFFF, 2, 3, 2};    // write across wrap
    for (int v = 0; v < 7; v++) begin
      set_req(vt[v].idx, vt[v].we, vt[v].addr, vt[v].len, 8'hA0);
      run_group(3'(1 << vt[v].idx));
      chk($sformatf("vec%0d done cycle", v), obs_done.size() > 0 ? obs_done[0] : -1, vt[v].exp_done);
      chk($sformatf("vec%0d beats", v), obs_beats, vt[v].exp_beats);
      chk($sformatf("vec%0d owner", v), obs_order.size() > 0 ? obs_order[0] : -1, vt[v].idx);
    end

    // contention: all three at once, len 2 reads
    do_reset();
    for (int i = 0; i < 3; i++) set_req(i, 0, 24'(32'h400 + 16 * i), 2, 0);
`ifdef DRAM_ARB_FETCH_PRIO_EN
    g_rereq[0] = 2;
    exp_ord = '{0, 0, 0, 1, 2}; exp_dn = '{4, 9, 14, 19, 24};
`else
    exp_ord = '{0, 1, 2}; exp_dn = '{4, 9, 14};
`endif
    run_group(3'b111);
    chk("contention count", obs_order.size(), exp_ord.size());
    for (int k = 0; k < exp_ord.size() && k < obs_order.size(); k++) begin
      chk($sformatf("contention order %0d", k), obs_order[k], exp_ord[k]);
      chk($sformatf("contention done %0d", k), obs_done[k], exp_dn[k]);
    end

    // reset mid-burst
    do_reset();
    set_req(0, 0, 24'h20, 1, 0);
    run_group(3'b001);                       // moves the pointer off 0
    req[1] = 1; req_we[1] = 0; req_addr[1] = 24'h40; req_len[1] = 20'd10;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mid beat3 mem_en", 32'(mem_en), 1);
    chk("rst_mid beat3 addr", 32'(mem_addr), 32'h42);
    #2 rst = 1;
    #1 expect_out("rst_mid async", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    req = 0;
    @(posedge clk); #1 rst = 0; ref_ptr = 0;
    seen = 0;
    repeat (12) begin @(negedge clk); if (xfer_done != 0 || busy) seen++; end
    chk("rst_mid no completion", seen, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) set_req(i, 0, 24'(32'h500 + i), 1, 0);
    run_group(3'b111);
    chk("rst_mid first winner", obs_order.size() > 0 ? obs_order[0] : -1, 0);

    // randomized groups against the model
    for (int r = 0; r < 40; r++) begin
      m = 3'($urandom_range(1, 7));
      for (int i = 0; i < 3; i++) begin
        g_we[i] = 1'($urandom_range(0, 1));
        g_addr[i] = ($urandom_range(0, 3) == 0) ? 24'hFFFFFC + 24'($urandom_range(0, 3))
                                                : 24'($urandom);
        g_len[i] = $urandom_range(0, 5);
        g_rereq[i] = (i == 0) ? $urandom_range(0, 1) : 0;
        for (int k = 0; k < 64; k++) g_w[i][k] = 8'($urandom);
      end
      run_group(m);
      chk($sformatf("rand%0d completions", r), obs_order.size(),
          $countones(m) + (m[0] ? g_rereq[0] : 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
